// File: rtl/phoenix_console_uart_tx_pkg.sv
// Shared definitions for the Phoenix console UART transmitter: bus encodings,
// serialiser state codes, status-word layout and the default console address.
package phoenix_console_uart_tx_pkg;

   localparam logic DMI_READ    = 1'b0;
   localparam logic DMI_WRITE   = 1'b1;
   localparam logic DMI_ENABLE  = 1'b1;
   localparam logic DMI_DISABLE = 1'b0;

   localparam logic [1:0] UART_IDLE  = 2'd0;
   localparam logic [1:0] UART_START = 2'd1;
   localparam logic [1:0] UART_DATA  = 2'd2;
   localparam logic [1:0] UART_STOP  = 2'd3;

   localparam int STAT_FULL      = 0;
   localparam int STAT_BUSY      = 1;
   localparam int STAT_OVF       = 2;
   localparam int STAT_COUNT_LSB = 8;

   localparam logic [31:0] CONSOLE_BASE_ADDRESS = 32'h1000_0000;

   // Builds the firmware-visible status word; unused bits read as zero.
   function automatic logic [31:0] pack_status(
      input logic [7:0] count,
      input logic       overflow,
      input logic       busy,
      input logic       full
   );
      logic [31:0] v_word;
      v_word                          = 32'h0000_0000;
      v_word[STAT_COUNT_LSB +: 8]     = count;
      v_word[STAT_OVF]                = overflow;
      v_word[STAT_BUSY]               = busy;
      v_word[STAT_FULL]               = full;
      return v_word;
   endfunction

endpackage

// File: rtl/phoenix_sync_fifo.sv
// Single-clock circular FIFO with wrap-around pointers. A push into a full
// FIFO is accepted only when a pop frees the head slot in the same cycle.
module phoenix_sync_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 8,
   parameter int ADDR_WIDTH = 3
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_push,
   input  logic [WIDTH-1:0]      i_push_data,
   input  logic                  i_pop,
   output logic [WIDTH-1:0]      o_head,
   output logic                  o_full,
   output logic                  o_empty,
   output logic [ADDR_WIDTH:0]   o_count
);

   localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = {(ADDR_WIDTH+1){1'b0}};
   localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] PTR_ZERO  = {ADDR_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

   logic [WIDTH-1:0]      r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  w_do_push;
   logic                  w_do_pop;

   assign o_full    = (r_count == CNT_DEPTH);
   assign o_empty   = (r_count == CNT_ZERO);
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= PTR_ZERO;
         r_rd_ptr <= PTR_ZERO;
         r_count  <= CNT_ZERO;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/phoenix_console_uart_tx.sv
// Memory-mapped console: byte writes at BASE_ADDRESS enter a FIFO and are sent
// as 8N1 frames on uart_tx; a status word at BASE_ADDRESS+4 lets firmware poll.
module phoenix_console_uart_tx
   import phoenix_console_uart_tx_pkg::*;
#(
   parameter logic [31:0] BASE_ADDRESS    = CONSOLE_BASE_ADDRESS,
   parameter int          CLKS_PER_BIT    = 16,
   parameter int          FIFO_DEPTH      = 8,
   parameter int          FIFO_ADDR_WIDTH = 3
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        data_memory_interface_enable,
   input  logic        data_memory_interface_state,
   input  logic [31:0] data_memory_interface_address,
   input  logic [3:0]  data_memory_interface_frame_mask,
   inout  wire  [31:0] data_memory_interface_data,
   output logic        uart_tx,
   output logic        tx_idle
);

   localparam int                BAUD_W         = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LOAD      = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_ZERO      = {BAUD_W{1'b0}};
   localparam logic [BAUD_W-1:0] BAUD_ONE       = BAUD_W'(1);
   localparam logic [31:0]       STATUS_ADDRESS = BASE_ADDRESS + 32'd4;

   logic [1:0]               r_state;
   logic [BAUD_W-1:0]        r_baud;
   logic [2:0]               r_bit_idx;
   logic [7:0]               r_shift;
   logic                     r_uart_tx;
   logic                     r_overflow;

   logic                     w_sel_data;
   logic                     w_push_req;
   logic                     w_stat_rd;
   logic                     w_data_rd;
   logic                     w_pop;
   logic                     w_full;
   logic                     w_empty;
   logic                     w_busy;
   logic                     w_overflow_set;
   logic                     w_baud_done;
   logic [7:0]               w_head;
   logic [FIFO_ADDR_WIDTH:0] w_count;
   logic [31:0]              w_rdata;
   logic                     w_unused;

   assign w_sel_data = data_memory_interface_enable
                       && (data_memory_interface_address == BASE_ADDRESS);
   assign w_push_req = w_sel_data
                       && (data_memory_interface_state == DMI_WRITE)
                       && data_memory_interface_frame_mask[3];
   assign w_data_rd  = w_sel_data && (data_memory_interface_state == DMI_READ);
   assign w_stat_rd  = data_memory_interface_enable
                       && (data_memory_interface_state == DMI_READ)
                       && (data_memory_interface_address == STATUS_ADDRESS);

   assign w_busy         = (r_state != UART_IDLE);
   assign w_pop          = (r_state == UART_IDLE) && !w_empty;
   assign w_overflow_set = w_push_req && w_full && !w_pop;
   assign w_baud_done    = (r_baud == BAUD_ZERO);

   assign w_unused = ^{data_memory_interface_frame_mask[2:0],
                       data_memory_interface_data[31:8]};

   phoenix_sync_fifo #(
      .WIDTH      (8),
      .DEPTH      (FIFO_DEPTH),
      .ADDR_WIDTH (FIFO_ADDR_WIDTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_push_req),
      .i_push_data (data_memory_interface_data[7:0]),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_count     (w_count)
   );

   // Status is combinational so firmware sees it in the same bus cycle.
   always_comb begin
      w_rdata = 32'h0000_0000;
      if (w_stat_rd) begin
         w_rdata = pack_status(8'(w_count), r_overflow, w_busy, w_full);
      end else begin
         w_rdata = 32'h0000_0000;
      end
   end

   assign data_memory_interface_data = (w_stat_rd || w_data_rd) ? w_rdata : {32{1'bz}};

   // A new overflow in the read's own cycle must survive the read-clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_overflow <= 1'b0;
      end else if (w_overflow_set) begin
         r_overflow <= 1'b1;
      end else if (w_stat_rd) begin
         r_overflow <= 1'b0;
      end else begin
         r_overflow <= r_overflow;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= UART_IDLE;
         r_baud    <= BAUD_ZERO;
         r_bit_idx <= 3'd0;
         r_shift   <= 8'h00;
      end else begin
         case (r_state)
            UART_IDLE: begin
               if (!w_empty) begin
                  r_shift   <= w_head;
                  r_state   <= UART_START;
                  r_baud    <= BAUD_LOAD;
                  r_bit_idx <= 3'd0;
               end
            end
            UART_START: begin
               if (w_baud_done) begin
                  r_state   <= UART_DATA;
                  r_baud    <= BAUD_LOAD;
                  r_bit_idx <= 3'd0;
               end else begin
                  r_baud <= r_baud - BAUD_ONE;
               end
            end
            UART_DATA: begin
               if (w_baud_done) begin
                  r_shift <= {1'b0, r_shift[7:1]};
                  r_baud  <= BAUD_LOAD;
                  if (r_bit_idx == 3'd7) begin
                     r_state   <= UART_STOP;
                     r_bit_idx <= 3'd0;
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                  end
               end else begin
                  r_baud <= r_baud - BAUD_ONE;
               end
            end
            UART_STOP: begin
               if (w_baud_done) begin
                  r_state <= UART_IDLE;
                  r_baud  <= BAUD_ZERO;
               end else begin
                  r_baud <= r_baud - BAUD_ONE;
               end
            end
            default: begin
               r_state   <= UART_IDLE;
               r_baud    <= BAUD_ZERO;
               r_bit_idx <= 3'd0;
            end
         endcase
      end
   end

   // Line level follows the state one cycle later, keeping the pin glitch-free.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_uart_tx <= 1'b1;
      end else begin
         case (r_state)
            UART_START: r_uart_tx <= 1'b0;
            UART_DATA:  r_uart_tx <= r_shift[0];
            default:    r_uart_tx <= 1'b1;
         endcase
      end
   end

   assign uart_tx = r_uart_tx;
   assign tx_idle = (r_state == UART_IDLE) && w_empty;

endmodule

// File: tb/tb_phoenix_console_uart_tx.sv
// Bench for phoenix_console_uart_tx: directed tables and sequences plus random
// bus traffic, checked against a queue-level model and a line receiver.
module tb_phoenix_console_uart_tx;
   import phoenix_console_uart_tx_pkg::*;

   localparam int          CPB   = 4;
   localparam int          DEPTH = 4;
   localparam int          AW    = 2;
   localparam int          FRAME = 10 * CPB;
   localparam logic [31:0] BASE  = 32'h1000_0000;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic        t_en   = 1'b0;
   logic        t_st   = 1'b0;
   logic [31:0] t_addr = 32'h0;
   logic [3:0]  t_mask = 4'h0;
   logic [31:0] t_wd   = 32'h0;
   logic        drv_en = 1'b0;
   wire  [31:0] dmi_data;
   logic        uart_tx;
   logic        tx_idle;

   assign dmi_data = drv_en ? t_wd : 32'hzzzz_zzzz;
   always #5 clk = ~clk;

   phoenix_console_uart_tx #(
      .BASE_ADDRESS    (BASE),
      .CLKS_PER_BIT    (CPB),
      .FIFO_DEPTH      (DEPTH),
      .FIFO_ADDR_WIDTH (AW)
   ) dut (
      .clk                              (clk),
      .reset                            (rst_n),
      .data_memory_interface_enable     (t_en),
      .data_memory_interface_state      (t_st),
      .data_memory_interface_address    (t_addr),
      .data_memory_interface_frame_mask (t_mask),
      .data_memory_interface_data       (dmi_data),
      .uart_tx                          (uart_tx),
      .tx_idle                          (tx_idle)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
      end
   endtask

   // Reference model: a byte queue plus a "frame busy" countdown.
   logic [7:0] m_q[$];
   logic [7:0] exp_line[$];
   logic [7:0] rx_q[$];
   int         m_busy = 0;
   bit         m_ovf  = 1'b0;

   function automatic logic [31:0] model_status();
      logic [7:0] cnt;
      cnt = 8'(m_q.size());
      return {16'h0000, cnt, 5'b00000, m_ovf, (m_busy > 0), (m_q.size() == DEPTH)};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if (m_busy > 0 && exp_line.size() > 0) exp_line.delete(exp_line.size() - 1);
         m_q.delete();
         m_busy = 0;
         m_ovf  = 1'b0;
      end else begin
         bit pop, wr, rd, full_pre, ovf_set;
         pop      = (m_busy == 0) && (m_q.size() > 0);
         wr       = t_en && (t_st == DMI_WRITE) && (t_addr == BASE) && t_mask[3];
         rd       = t_en && (t_st == DMI_READ) && (t_addr == BASE + 32'd4);
         full_pre = (m_q.size() == DEPTH);
         ovf_set  = 1'b0;
         if (pop) begin
            exp_line.push_back(m_q.pop_front());
            m_busy = FRAME;
         end else if (m_busy > 0) begin
            m_busy--;
         end
         if (wr) begin
            if (!full_pre || pop) m_q.push_back(t_wd[7:0]);
            else ovf_set = 1'b1;
         end
         if (ovf_set) m_ovf = 1'b1;
         else if (rd) m_ovf = 1'b0;
      end
   end

   // Line receiver: samples mid-bit on the falling clock edge.
   bit         rx_on = 1'b0;
   int         rx_t  = 0;
   logic [7:0] rx_sh = 8'h00;

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_on = 1'b0;
         rx_t  = 0;
      end else if (!rx_on) begin
         if (uart_tx === 1'b0) begin
            rx_on = 1'b1;
            rx_t  = 0;
         end
      end else begin
         rx_t++;
         if (rx_t == CPB / 2) begin
            check("rx start bit", {31'b0, uart_tx}, 32'h0);
         end else if (rx_t == 9 * CPB + CPB / 2) begin
            check("rx stop bit", {31'b0, uart_tx}, 32'h1);
            rx_q.push_back(rx_sh);
            rx_on = 1'b0;
         end else if ((rx_t % CPB) == CPB / 2) begin
            rx_sh[(rx_t / CPB) - 1] = uart_tx;
         end
      end
   end

   bit chk_idle = 1'b0;
   always @(negedge clk) begin
      if (chk_idle) check("tx_idle vs model", {31'b0, tx_idle}, {31'b0, (m_busy == 0 && m_q.size() == 0)});
   end

   task automatic access(input logic en, input logic st, input logic [31:0] addr,
                         input logic [3:0] mask, input logic [31:0] wd, output logic [31:0] rd);
      t_en   = en;
      t_st   = st;
      t_addr = addr;
      t_mask = mask;
      t_wd   = wd;
      drv_en = en && (st == DMI_WRITE);
      @(negedge clk);
      rd = dmi_data;
      @(posedge clk);
      #1;
      t_en   = 1'b0;
      drv_en = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int k = 0;
      while (!(tx_idle === 1'b1 && m_busy == 0 && m_q.size() == 0) && k < budget) begin
         @(negedge clk);
         k++;
      end
      check({name, " idle within budget"}, {31'b0, (k < budget)}, 32'h1);
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        en;
      logic        st;
      logic [31:0] addr;
      logic [3:0]  mask;
      logic [31:0] wd;
      logic [31:0] exp_status;
   } vec_t;

   localparam int NV = 9;
   vec_t vecs[NV];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      int          lat, n, base_sz, lows;
      bit          found;

      vecs[0] = '{1'b1, DMI_WRITE, BASE,             4'b1000, 32'h0000_00A7, 32'h0000_0100};
      vecs[1] = '{1'b1, DMI_WRITE, BASE,             4'b0001, 32'h0000_00B1, 32'h0000_0000};
      vecs[2] = '{1'b1, DMI_WRITE, BASE,             4'b1111, 32'h1234_5678, 32'h0000_0100};
      vecs[3] = '{1'b1, DMI_WRITE, BASE + 32'd4,     4'b1000, 32'h0000_00C3, 32'h0000_0000};
      vecs[4] = '{1'b1, DMI_WRITE, BASE + 32'd8,     4'b1000, 32'h0000_00C4, 32'h0000_0000};
      vecs[5] = '{1'b0, DMI_WRITE, BASE,             4'b1000, 32'h0000_00C5, 32'h0000_0000};
      vecs[6] = '{1'b1, DMI_READ,  BASE,             4'b1000, 32'h0000_0000, 32'h0000_0000};
      vecs[7] = '{1'b1, DMI_WRITE, 32'h1000_0001,    4'b1000, 32'h0000_00C7, 32'h0000_0000};
      vecs[8] = '{1'b1, DMI_WRITE, BASE,             4'b0111, 32'hFFFF_FF00, 32'h0000_0000};

      // Reset hold and release.
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset uart_tx", {31'b0, uart_tx}, 32'h1);
      check("reset tx_idle", {31'b0, tx_idle}, 32'h1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      access(1'b1, DMI_READ, BASE + 32'd4, 4'b1111, 32'h0, rd);
      check("status after reset", rd, 32'h0000_0000);
      access(1'b1, DMI_READ, BASE, 4'b1111, 32'h0, rd);
      check("data reg read", rd, 32'h0000_0000);
      check("uart_tx after release", {31'b0, uart_tx}, 32'h1);

      // Single byte 0x41: latency, start width, frame length.
      base_sz = rx_q.size();
      access(1'b1, DMI_WRITE, BASE, 4'b1000, 32'h0000_0041, rd);
      found = 1'b0;
      lat   = -1;
      for (int k = 1; k <= 10 && !found; k++) begin
         @(negedge clk);
         if (uart_tx === 1'b0) begin
            found = 1'b1;
            lat   = k - 1;
         end
      end
      check("fall latency", 32'(lat), 32'd2);
      n = 1;
      @(negedge clk);
      while (uart_tx === 1'b0 && n < 2 * CPB) begin
         n++;
         @(negedge clk);
      end
      check("start bit width", 32'(n), 32'(CPB));
      while (tx_idle !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("fall to tx_idle cycles", 32'(n), 32'(FRAME - 1));
      check("0x41 frame count", 32'(rx_q.size()), 32'(base_sz + 1));
      if (rx_q.size() > 0) check("0x41 byte", {24'h0, rx_q[rx_q.size() - 1]}, 32'h41);
      @(posedge clk);
      #1;

      // Table-driven single accesses.
      for (int i = 0; i < NV; i++) begin
         wait_idle("vector", 200);
         access(vecs[i].en, vecs[i].st, vecs[i].addr, vecs[i].mask, vecs[i].wd, rd);
         if (vecs[i].st == DMI_READ) check("vector read data", rd, 32'h0000_0000);
         access(1'b1, DMI_READ, BASE + 32'd4, 4'b1111, 32'h0, rd);
         check("vector status", rd, vecs[i].exp_status);
         @(negedge clk);
         @(negedge clk);
         check("vector line", {31'b0, uart_tx}, {31'b0, ~vecs[i].exp_status[8]});
      end
      wait_idle("table drain", 200);

      // Six back-to-back bytes: one pops, four queue, one overflows.
      base_sz = rx_q.size();
      for (int i = 0; i < 6; i++) access(1'b1, DMI_WRITE, BASE, 4'b1000, 32'h30 + 32'(i), rd);
      access(1'b1, DMI_READ, BASE + 32'd4, 4'b1111, 32'h0, rd);
      check("burst status", rd, 32'h0000_0407);
      access(1'b1, DMI_READ, BASE + 32'd4, 4'b1111, 32'h0, rd);
      check("burst status ovf cleared", rd, 32'h0000_0403);
      wait_idle("burst drain", 400);
      check("burst frame count", 32'(rx_q.size()), 32'(base_sz + 5));
      for (int i = 0; i < 5 && base_sz + i < rx_q.size(); i++)
         check("burst byte", {24'h0, rx_q[base_sz + i]}, 32'h30 + 32'(i));

      // Full FIFO with a write landing on the pop cycle.
      for (int i = 0; i < 5; i++) access(1'b1, DMI_WRITE, BASE, 4'b1000, 32'h61 + 32'(i), rd);
      n = 0;
      while (m_busy != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("pop-cycle reached", {31'b0, (n < 100)}, 32'h1);
      access(1'b1, DMI_WRITE, BASE, 4'b1000, 32'h0000_0066, rd);
      access(1'b1, DMI_READ, BASE + 32'd4, 4'b1111, 32'h0, rd);
      check("full+pop status", rd, 32'h0000_0403);
      check("full+pop model status", rd, model_status());
      wait_idle("full+pop drain", 400);

      // Reset in the middle of a frame.
      base_sz = rx_q.size();
      access(1'b1, DMI_WRITE, BASE, 4'b1000, 32'h0000_0055, rd);
      access(1'b1, DMI_WRITE, BASE, 4'b1000, 32'h0000_0056, rd);
      access(1'b1, DMI_WRITE, BASE, 4'b1000, 32'h0000_0057, rd);
      repeat (9) @(posedge clk);
      #2;
      check("line low before reset", {31'b0, uart_tx}, 32'h0);
      rst_n = 1'b0;
      #1;
      check("async reset line high", {31'b0, uart_tx}, 32'h1);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      access(1'b1, DMI_READ, BASE + 32'd4, 4'b1111, 32'h0, rd);
      check("status after mid reset", rd, 32'h0000_0000);
      lows = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) lows++;
      end
      check("no frames after reset", 32'(lows), 32'h0);
      check("no bytes after reset", 32'(rx_q.size()), 32'(base_sz));
      @(posedge clk);
      #1;

      // Random traffic against the model.
      chk_idle = 1'b1;
      for (int it = 0; it < 600; it++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 30) begin
            logic [3:0] mk;
            mk    = 4'($urandom_range(0, 15));
            mk[3] = ($urandom_range(0, 9) < 8);
            access(1'b1, DMI_WRITE, BASE, mk, $urandom, rd);
         end else if (r < 50) begin
            logic [31:0] es;
            t_en = 1'b1; t_st = DMI_READ; t_addr = BASE + 32'd4; t_mask = 4'hF;
            @(negedge clk);
            es = model_status();
            check("random status", dmi_data, es);
            @(posedge clk);
            #1;
            t_en = 1'b0;
         end else if (r < 55) begin
            access(1'b1, DMI_READ, BASE, 4'hF, 32'h0, rd);
            check("random data read", rd, 32'h0);
         end else if (r < 65) begin
            access(1'b1, DMI_WRITE, BASE + 32'(4 * $urandom_range(1, 3)), 4'b1000, $urandom, rd);
         end else begin
            access(1'b0, DMI_WRITE, BASE, 4'b1000, $urandom, rd);
         end
      end
      wait_idle("random drain", 600);
      chk_idle = 1'b0;

      check("line byte count", 32'(rx_q.size()), 32'(exp_line.size()));
      for (int i = 0; i < exp_line.size() && i < rx_q.size(); i++)
         check("line byte", {24'h0, rx_q[i]}, {24'h0, exp_line[i]});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
